// File: rtl/game_flow_seq.sv
// Game-flow sequencer: chains N_LEVELS level modules with a lives budget and
// switches the displayed pixel source only on frame boundaries.
module game_flow_seq #(
  parameter int N_LEVELS = 2,
  parameter int PIX_W    = 12,
  parameter int LIVES    = 1,
  parameter int LVL_W    = 3
) (
  input  logic                      CLK,
  input  logic                      RST_BTN,
  input  logic                      pix_stb,
  input  logic                      frame_end,
  input  logic                      start_btn,
  input  logic [PIX_W-1:0]          start_pix,
  input  logic [PIX_W-1:0]          win_pix,
  input  logic [PIX_W-1:0]          lose_pix,
  input  logic [N_LEVELS*PIX_W-1:0] lvl_pix,
  input  logic [N_LEVELS-1:0]       lvl_over,
  input  logic [N_LEVELS-1:0]       lvl_result,
  output logic [N_LEVELS-1:0]       lvl_start,
  output logic [PIX_W-1:0]          vga_out,
  output logic [LVL_W-1:0]          level,
  output logic [2:0]                lives_left,
  output logic [2:0]                state
);

  localparam int unsigned NSLOT = 2**LVL_W;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LAUNCH = 3'd1,
    PLAY   = 3'd2,
    WIN    = 3'd3,
    LOSE   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SRC_START,
    SRC_LEVEL,
    SRC_WIN,
    SRC_LOSE
  } src_e;

  state_e           state_q, state_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [2:0]       lives_q, lives_d;
  logic             armed_q, armed_d;
  logic             start_prev_q;
  src_e             disp_sel_q, disp_sel_d, target_sel;
  logic [LVL_W-1:0] disp_lvl_q, disp_lvl_d;
  logic [PIX_W-1:0] vga_q, vga_d, src_pix;

  logic             start_edge;
  logic [NSLOT-1:0] over_ext, result_ext;
  logic [PIX_W-1:0] lvl_pix_arr [NSLOT];

  assign start_edge = start_btn & ~start_prev_q;

  // Widen per-level inputs to the full index range so level_q indexes safely.
  always_comb begin
    over_ext                  = '0;
    result_ext                = '0;
    over_ext[N_LEVELS-1:0]    = lvl_over;
    result_ext[N_LEVELS-1:0]  = lvl_result;
    for (int unsigned k = 0; k < NSLOT; k++) lvl_pix_arr[k] = '0;
    for (int unsigned k = 0; k < N_LEVELS; k++) lvl_pix_arr[k] = lvl_pix[k*PIX_W +: PIX_W];
  end

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    lives_d = lives_q;
    armed_d = armed_q;
    case (state_q)
      IDLE, WIN, LOSE: begin
        if (start_edge) begin
          level_d = '0;
          lives_d = 3'(LIVES);
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        armed_d = 1'b0;
        state_d = PLAY;
      end
      PLAY: begin
        if (start_edge) begin
          level_d = '0;
          lives_d = 3'(LIVES);
          state_d = LAUNCH;
        end else if (!armed_q) begin
          // A level only counts as finished after its over flag was seen low.
          if (!over_ext[level_q]) armed_d = 1'b1;
        end else if (over_ext[level_q]) begin
          if (result_ext[level_q]) begin
            if (level_q == LVL_W'(N_LEVELS-1)) begin
              state_d = WIN;
            end else begin
              level_d = level_q + 1'b1;
              state_d = LAUNCH;
            end
          end else if (lives_q != '0) begin
            lives_d = lives_q - 1'b1;
            state_d = LAUNCH;
          end else begin
            state_d = LOSE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    case (state_q)
      LAUNCH, PLAY: target_sel = SRC_LEVEL;
      WIN:          target_sel = SRC_WIN;
      LOSE:         target_sel = SRC_LOSE;
      default:      target_sel = SRC_START;
    endcase
    disp_sel_d = frame_end ? target_sel : disp_sel_q;
    disp_lvl_d = frame_end ? level_q : disp_lvl_q;

    src_pix = '0;
    case (disp_sel_q)
      SRC_START: src_pix = start_pix;
      SRC_LEVEL: src_pix = lvl_pix_arr[disp_lvl_q];
      SRC_WIN:   src_pix = win_pix;
      SRC_LOSE:  src_pix = lose_pix;
      default:   src_pix = '0;
    endcase
    vga_d = pix_stb ? src_pix : vga_q;
  end

  always_ff @(posedge CLK or negedge RST_BTN) begin
    if (!RST_BTN) begin
      state_q      <= IDLE;
      level_q      <= '0;
      lives_q      <= 3'(LIVES);
      armed_q      <= 1'b0;
      start_prev_q <= 1'b0;
      disp_sel_q   <= SRC_START;
      disp_lvl_q   <= '0;
      vga_q        <= '0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      armed_q      <= armed_d;
      start_prev_q <= start_btn;
      disp_sel_q   <= disp_sel_d;
      disp_lvl_q   <= disp_lvl_d;
      vga_q        <= vga_d;
    end
  end

  always_comb begin
    lvl_start = '0;
    for (int unsigned k = 0; k < N_LEVELS; k++)
      lvl_start[k] = (state_q == LAUNCH) && (level_q == LVL_W'(k));
  end

  assign vga_out    = vga_q;
  assign level      = level_q;
  assign lives_left = lives_q;
  assign state      = state_q;

endmodule

// File: tb/tb_game_flow_seq.sv
// Directed table-driven bench for game_flow_seq with N_LEVELS=2, LIVES=1.
module tb_game_flow_seq;

  localparam int NL = 2;
  localparam int PW = 12;

  logic          CLK = 1'b0;
  logic          RST_BTN = 1'b1;
  logic          pix_stb = 1'b0, frame_end = 1'b0, start_btn = 1'b0;
  logic [PW-1:0] start_pix = 12'hF00, win_pix = 12'hABC, lose_pix = 12'h555;
  logic [NL*PW-1:0] lvl_pix = {12'h00F, 12'h0F0};
  logic [NL-1:0] lvl_over = '0, lvl_result = '0;
  logic [NL-1:0] lvl_start;
  logic [PW-1:0] vga_out;
  logic [2:0]    level, lives_left, state;

  int checks = 0;
  int failures = 0;

  game_flow_seq #(.N_LEVELS(NL), .PIX_W(PW), .LIVES(1), .LVL_W(3)) dut (
    .CLK(CLK), .RST_BTN(RST_BTN), .pix_stb(pix_stb), .frame_end(frame_end),
    .start_btn(start_btn), .start_pix(start_pix), .win_pix(win_pix),
    .lose_pix(lose_pix), .lvl_pix(lvl_pix), .lvl_over(lvl_over),
    .lvl_result(lvl_result), .lvl_start(lvl_start), .vga_out(vga_out),
    .level(level), .lives_left(lives_left), .state(state)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic       sb, fe, ps;
    logic [1:0] ov, rs;
    logic [2:0] st, lv, li;
    logic [1:0] ls;
    logic [11:0] vg;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(logic sb, logic fe, logic ps, logic [1:0] ov, logic [1:0] rs,
                              logic [2:0] st, logic [2:0] lv, logic [2:0] li,
                              logic [1:0] ls, logic [11:0] vg);
    vec_t v;
    v.sb = sb; v.fe = fe; v.ps = ps; v.ov = ov; v.rs = rs;
    v.st = st; v.lv = lv; v.li = li; v.ls = ls; v.vg = vg;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s vec=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [2:0] st, input logic [2:0] lv,
                         input logic [2:0] li, input logic [1:0] ls, input logic [11:0] vg);
    chk("state", idx, 32'(state), 32'(st));
    chk("level", idx, 32'(level), 32'(lv));
    chk("lives_left", idx, 32'(lives_left), 32'(li));
    chk("lvl_start", idx, 32'(lvl_start), 32'(ls));
    chk("vga_out", idx, 32'(vga_out), 32'(vg));
  endtask

  initial begin
    //             sb fe ps ov     rs     st lv li ls     vga
    vt.push_back(mk(0, 0, 1, 2'b00, 2'b00, 0, 0, 1, 2'b00, 12'hF00)); // 0 idle strobe
    vt.push_back(mk(0, 0, 0, 2'b00, 2'b00, 0, 0, 1, 2'b00, 12'hF00)); // 1 hold
    vt.push_back(mk(1, 0, 0, 2'b00, 2'b00, 1, 0, 1, 2'b01, 12'hF00)); // 2 start -> LAUNCH
    vt.push_back(mk(1, 0, 1, 2'b00, 2'b00, 2, 0, 1, 2'b00, 12'hF00)); // 3 PLAY, still start screen
    vt.push_back(mk(0, 1, 1, 2'b00, 2'b00, 2, 0, 1, 2'b00, 12'hF00)); // 4 frame_end switches sel
    vt.push_back(mk(0, 0, 1, 2'b00, 2'b00, 2, 0, 1, 2'b00, 12'h0F0)); // 5 level 0 pixel
    vt.push_back(mk(0, 0, 0, 2'b01, 2'b01, 1, 1, 1, 2'b10, 12'h0F0)); // 6 lvl0 win -> lvl1
    vt.push_back(mk(0, 0, 0, 2'b01, 2'b01, 2, 1, 1, 2'b00, 12'h0F0)); // 7
    vt.push_back(mk(0, 1, 1, 2'b00, 2'b00, 2, 1, 1, 2'b00, 12'h0F0)); // 8 arm, frame_end
    vt.push_back(mk(0, 0, 1, 2'b00, 2'b00, 2, 1, 1, 2'b00, 12'h00F)); // 9 level 1 pixel
    vt.push_back(mk(0, 0, 0, 2'b10, 2'b10, 3, 1, 1, 2'b00, 12'h00F)); // 10 last level win
    vt.push_back(mk(0, 1, 1, 2'b10, 2'b10, 3, 1, 1, 2'b00, 12'h00F)); // 11 frame_end
    vt.push_back(mk(0, 0, 1, 2'b10, 2'b10, 3, 1, 1, 2'b00, 12'hABC)); // 12 win pixel
    vt.push_back(mk(1, 0, 0, 2'b10, 2'b10, 1, 0, 1, 2'b01, 12'hABC)); // 13 restart
    vt.push_back(mk(0, 0, 0, 2'b01, 2'b00, 2, 0, 1, 2'b00, 12'hABC)); // 14 stale over held
    vt.push_back(mk(0, 0, 0, 2'b01, 2'b00, 2, 0, 1, 2'b00, 12'hABC)); // 15 ignored
    vt.push_back(mk(0, 0, 0, 2'b01, 2'b00, 2, 0, 1, 2'b00, 12'hABC)); // 16 ignored
    vt.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2, 0, 1, 2'b00, 12'hABC)); // 17 arm
    vt.push_back(mk(0, 0, 0, 2'b01, 2'b00, 1, 0, 0, 2'b01, 12'hABC)); // 18 loss, retry
    vt.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2, 0, 0, 2'b00, 12'hABC)); // 19
    vt.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2, 0, 0, 2'b00, 12'hABC)); // 20 arm
    vt.push_back(mk(0, 0, 0, 2'b01, 2'b00, 4, 0, 0, 2'b00, 12'hABC)); // 21 loss, no lives
    vt.push_back(mk(0, 1, 1, 2'b01, 2'b00, 4, 0, 0, 2'b00, 12'hABC)); // 22 frame_end
    vt.push_back(mk(0, 0, 1, 2'b01, 2'b00, 4, 0, 0, 2'b00, 12'h555)); // 23 lose pixel
    vt.push_back(mk(1, 0, 0, 2'b00, 2'b00, 1, 0, 1, 2'b01, 12'h555)); // 24 restart
    vt.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2, 0, 1, 2'b00, 12'h555)); // 25
    vt.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2, 0, 1, 2'b00, 12'h555)); // 26 arm
    vt.push_back(mk(0, 0, 0, 2'b01, 2'b01, 1, 1, 1, 2'b10, 12'h555)); // 27 lvl0 win
    vt.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2, 1, 1, 2'b00, 12'h555)); // 28
    vt.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2, 1, 1, 2'b00, 12'h555)); // 29 arm
    vt.push_back(mk(1, 0, 0, 2'b10, 2'b10, 1, 0, 1, 2'b01, 12'h555)); // 30 start beats over
    vt.push_back(mk(0, 0, 0, 2'b00, 2'b00, 2, 0, 1, 2'b00, 12'h555)); // 31 PLAY

    // Async reset with no clock edge in between.
    #2 RST_BTN = 1'b0;
    #1 chk_all(-1, 3'd0, 3'd0, 3'd1, 2'b00, 12'h000);
    @(negedge CLK);
    @(negedge CLK);
    RST_BTN = 1'b1;

    foreach (vt[i]) begin
      start_btn  = vt[i].sb;
      frame_end  = vt[i].fe;
      pix_stb    = vt[i].ps;
      lvl_over   = vt[i].ov;
      lvl_result = vt[i].rs;
      @(posedge CLK);
      #1 chk_all(i, vt[i].st, vt[i].lv, vt[i].li, vt[i].ls, vt[i].vg);
    end

    // Reset asserted mid-PLAY must clear outputs before the next edge.
    #2 RST_BTN = 1'b0;
    #1 chk_all(100, 3'd0, 3'd0, 3'd1, 2'b00, 12'h000);

    // Held in reset, a clock edge with start_btn high must not launch.
    start_btn = 1'b1;
    @(posedge CLK);
    #1 chk_all(101, 3'd0, 3'd0, 3'd1, 2'b00, 12'h000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
